// File: rtl/csi2_pkg.sv
// ----------------------------------------------------------------------------
// csi2_pkg
//   Shared definitions for the CSI-2 frame controller:
//   - data-type codes of the short packets the sequencer reacts to and the
//     boundary above which a data type denotes a long packet
//   - packet header layout as carried on the converter stream
//   - frame sequencer state encoding
//   - small helpers to pull header fields out of a raw 32-bit beat
// ----------------------------------------------------------------------------
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef struct packed {
        logic [7:0]  ecc;
        logic [15:0] wc;
        logic [1:0]  vc;
        logic [5:0]  dt;
    } csi2_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_FRAME   = 2'd2
    } frame_state_e;

    function automatic logic [5:0] hdr_dt(input csi2_hdr_t h);
        return h.dt;
    endfunction

    function automatic logic [1:0] hdr_vc(input csi2_hdr_t h);
        return h.vc;
    endfunction

    function automatic logic [15:0] hdr_wc(input csi2_hdr_t h);
        return h.wc;
    endfunction

    function automatic logic is_long_dt(input logic [5:0] dt);
        return dt >= DT_LONG_MIN;
    endfunction

endpackage

// File: rtl/csi2_payload_strip.sv
// ----------------------------------------------------------------------------
// csi2_payload_strip
//   Turns the payload beats of one forwarded long packet into video beats.
//   Tracks the bytes still owed by the word count, generates tkeep/tlast and
//   drops the trailing beats that only carry CRC bytes. Video outputs are
//   registered and held at zero whenever no beat is emitted.
// Ports
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   load_i, wc_i      forwarded header seen: load remaining byte count
//   beat_i            payload beat of a forwarded packet
//   last_i            packet tlast on that beat
//   sof_i             start-of-frame pending (becomes tuser)
//   data_i            payload word
//   take_o            combinational: this beat is emitted
//   eol_o             combinational: this beat closes the line
//   vid_*_o           registered video stream
// ----------------------------------------------------------------------------
module csi2_payload_strip
    import csi2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [15:0] wc_i,
    input  logic        beat_i,
    input  logic        last_i,
    input  logic        sof_i,
    input  logic [31:0] data_i,
    output logic        take_o,
    output logic        eol_o,
    output logic        vid_tvalid_o,
    output logic [31:0] vid_tdata_o,
    output logic [3:0]  vid_tkeep_o,
    output logic        vid_tuser_o,
    output logic        vid_tlast_o
);

    logic [15:0] rem_q, rem_d;
    logic        vid_tvalid_q, vid_tvalid_d;
    logic [31:0] vid_tdata_q, vid_tdata_d;
    logic [3:0]  vid_tkeep_q, vid_tkeep_d;
    logic        vid_tuser_q, vid_tuser_d;
    logic        vid_tlast_q, vid_tlast_d;
    logic        line_end;

    // Mask for a partial final word holding 1..3 payload bytes.
    function automatic logic [3:0] keep_mask(input logic [1:0] n);
        case (n)
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    always_comb begin
        rem_d        = rem_q;
        vid_tvalid_d = 1'b0;
        vid_tdata_d  = '0;
        vid_tkeep_d  = '0;
        vid_tuser_d  = 1'b0;
        vid_tlast_d  = 1'b0;
        take_o       = beat_i && (rem_q != 16'd0);
        // A packet cut short by tlast still closes the line so the sink
        // never sees an unterminated line.
        line_end     = (rem_q <= 16'd4) || last_i;
        eol_o        = take_o && line_end;

        if (load_i) begin
            rem_d = wc_i;
        end else if (take_o) begin
            vid_tvalid_d = 1'b1;
            vid_tdata_d  = data_i;
            vid_tuser_d  = sof_i;
            vid_tkeep_d  = (rem_q >= 16'd4) ? 4'hF : keep_mask(rem_q[1:0]);
            vid_tlast_d  = line_end;
            rem_d        = line_end ? 16'd0 : rem_q - 16'd4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q        <= '0;
            vid_tvalid_q <= 1'b0;
            vid_tdata_q  <= '0;
            vid_tkeep_q  <= '0;
            vid_tuser_q  <= 1'b0;
            vid_tlast_q  <= 1'b0;
        end else begin
            rem_q        <= rem_d;
            vid_tvalid_q <= vid_tvalid_d;
            vid_tdata_q  <= vid_tdata_d;
            vid_tkeep_q  <= vid_tkeep_d;
            vid_tuser_q  <= vid_tuser_d;
            vid_tlast_q  <= vid_tlast_d;
        end
    end

    assign vid_tvalid_o = vid_tvalid_q;
    assign vid_tdata_o  = vid_tdata_q;
    assign vid_tkeep_o  = vid_tkeep_q;
    assign vid_tuser_o  = vid_tuser_q;
    assign vid_tlast_o  = vid_tlast_q;

endmodule

// File: rtl/csi2_frame_ctrl.sv
// ----------------------------------------------------------------------------
// csi2_frame_ctrl
//   Frame-level sequencer behind the CSI-2 packet converter. Enables the
//   converter while armed, parses its packet stream, follows FS/LS/LE/FE and
//   forwards the payload of matching long packets as a video stream
//   (tuser = start of frame, tlast = end of line). Keeps frame/line stats and
//   sticky error flags.
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   start_i, stop_i       CSR pulses: arm / stop after current frame
//   one_shot_i            CSR level: one frame per start
//   exp_lines_i           expected lines per frame, 0 disables the check
//   pkt_t*_i              converter packet stream (no backpressure)
//   conv_en_o             converter enable
//   vid_t*_o              video stream, one cycle after the input beat
//   busy_o                sequencer not idle
//   frame_cnt_o           completed frames
//   line_cnt_o            lines in the last completed frame
//   err_o                 sticky {lines_mismatch, missing_fe, orphan_pkt}
// ----------------------------------------------------------------------------
module csi2_frame_ctrl
    import csi2_pkg::*;
#(
    parameter logic [5:0] DATA_TYPE = 6'h2B,
    parameter logic [1:0] VIRT_CHAN = 2'd0,
    parameter int         CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             one_shot_i,
    input  logic [CNT_W-1:0] exp_lines_i,
    input  logic             pkt_tvalid_i,
    input  logic [31:0]      pkt_tdata_i,
    input  logic             pkt_tlast_i,
    output logic             conv_en_o,
    output logic             vid_tvalid_o,
    output logic [31:0]      vid_tdata_o,
    output logic [3:0]       vid_tkeep_o,
    output logic             vid_tuser_o,
    output logic             vid_tlast_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic [2:0]       err_o
);

    frame_state_e     state_q, state_d;
    logic             exp_hdr_q, exp_hdr_d;
    logic             fwd_q, fwd_d;
    logic             sof_q, sof_d;
    logic             stop_pend_q, stop_pend_d;
    logic             conv_en_q, conv_en_d;
    logic [CNT_W-1:0] line_ctr_q, line_ctr_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [2:0]       err_q, err_d;

    logic        hdr_beat, pay_beat, on_vc, load, take, eol;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [2:0]  err_set;

    always_comb begin
        dt       = hdr_dt(csi2_hdr_t'(pkt_tdata_i));
        wc       = hdr_wc(csi2_hdr_t'(pkt_tdata_i));
        on_vc    = hdr_vc(csi2_hdr_t'(pkt_tdata_i)) == VIRT_CHAN;
        hdr_beat = pkt_tvalid_i && exp_hdr_q;
        pay_beat = pkt_tvalid_i && !exp_hdr_q;

        // Every tlast re-arms header detection, so a beat after any packet
        // end (or after reset) is parsed as a header.
        exp_hdr_d = pkt_tvalid_i ? pkt_tlast_i : exp_hdr_q;

        load = hdr_beat && on_vc && (state_q == ST_FRAME) &&
               (dt == DATA_TYPE) && !pkt_tlast_i;
        fwd_d = fwd_q;
        if (hdr_beat) begin
            fwd_d = load;
        end else if (pay_beat && pkt_tlast_i) begin
            fwd_d = 1'b0;
        end
    end

    csi2_payload_strip u_strip (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .load_i       (load),
        .wc_i         (wc),
        .beat_i       (pay_beat && fwd_q),
        .last_i       (pkt_tlast_i),
        .sof_i        (sof_q),
        .data_i       (pkt_tdata_i),
        .take_o       (take),
        .eol_o        (eol),
        .vid_tvalid_o (vid_tvalid_o),
        .vid_tdata_o  (vid_tdata_o),
        .vid_tkeep_o  (vid_tkeep_o),
        .vid_tuser_o  (vid_tuser_o),
        .vid_tlast_o  (vid_tlast_o)
    );

    always_comb begin
        state_d     = state_q;
        sof_d       = sof_q;
        stop_pend_d = stop_pend_q;
        line_ctr_d  = line_ctr_q;
        frame_cnt_d = frame_cnt_q;
        line_cnt_d  = line_cnt_q;
        err_set     = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d     = ST_WAIT_FS;
                    stop_pend_d = 1'b0;
                end
            end
            ST_WAIT_FS: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (hdr_beat && on_vc) begin
                    if (dt == DT_FS) begin
                        state_d    = ST_FRAME;
                        line_ctr_d = '0;
                        sof_d      = 1'b1;
                    end else if (dt == DT_FE || is_long_dt(dt)) begin
                        err_set[0] = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (hdr_beat && on_vc) begin
                    if (dt == DT_FS) begin
                        // Previous frame lost its FE: abandon it uncounted.
                        err_set[1] = 1'b1;
                        line_ctr_d = '0;
                        sof_d      = 1'b1;
                    end else if (dt == DT_FE) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        line_cnt_d  = line_ctr_q;
                        if (exp_lines_i != '0 && exp_lines_i != line_ctr_q) begin
                            err_set[2] = 1'b1;
                        end
                        state_d     = (one_shot_i || stop_pend_q || stop_i) ?
                                      ST_IDLE : ST_WAIT_FS;
                        stop_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Payload and headers never share a beat, so this cannot collide
        // with the FS clear above.
        if (eol) begin
            line_ctr_d = line_ctr_q + CNT_W'(1);
        end
        if (take) begin
            sof_d = 1'b0;
        end

        err_d     = (start_i ? 3'b000 : err_q) | err_set;
        conv_en_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            exp_hdr_q   <= 1'b1;
            fwd_q       <= 1'b0;
            sof_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            conv_en_q   <= 1'b0;
            line_ctr_q  <= '0;
            frame_cnt_q <= '0;
            line_cnt_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            exp_hdr_q   <= exp_hdr_d;
            fwd_q       <= fwd_d;
            sof_q       <= sof_d;
            stop_pend_q <= stop_pend_d;
            conv_en_q   <= conv_en_d;
            line_ctr_q  <= line_ctr_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
            err_q       <= err_d;
        end
    end

    assign conv_en_o   = conv_en_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_cnt_o = frame_cnt_q;
    assign line_cnt_o  = line_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csi2_frame_ctrl
//   Directed bench for csi2_frame_ctrl: a table of packet-stream beats with
//   hand-computed video outputs, applied in groups, interleaved with CSR
//   pulses and status checks for the multi-cycle corner cases.
// ----------------------------------------------------------------------------
module tb_csi2_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, one_shot;
    logic [15:0] exp_lines;
    logic        pkt_tvalid;
    logic [31:0] pkt_tdata;
    logic        pkt_tlast;
    logic        conv_en, vid_tvalid, vid_tuser, vid_tlast, busy;
    logic [31:0] vid_tdata;
    logic [3:0]  vid_tkeep;
    logic [15:0] frame_cnt, line_cnt;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csi2_frame_ctrl #(.DATA_TYPE(6'h2B), .VIRT_CHAN(2'd0), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .stop_i       (stop),
        .one_shot_i   (one_shot),
        .exp_lines_i  (exp_lines),
        .pkt_tvalid_i (pkt_tvalid),
        .pkt_tdata_i  (pkt_tdata),
        .pkt_tlast_i  (pkt_tlast),
        .conv_en_o    (conv_en),
        .vid_tvalid_o (vid_tvalid),
        .vid_tdata_o  (vid_tdata),
        .vid_tkeep_o  (vid_tkeep),
        .vid_tuser_o  (vid_tuser),
        .vid_tlast_o  (vid_tlast),
        .busy_o       (busy),
        .frame_cnt_o  (frame_cnt),
        .line_cnt_o   (line_cnt),
        .err_o        (err)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        ev;
        logic [3:0]  k;
        logic        u;
        logic        el;
    } vec_t;

    vec_t vec [0:79];
    int   nvec = 0;

    function automatic logic [31:0] hdr(input logic [5:0] dt, input logic [1:0] vc,
                                        input logic [15:0] wc);
        return {8'h00, wc, vc, dt};
    endfunction

    task automatic add(input logic [31:0] d, input logic l, input logic ev,
                       input logic [3:0] k, input logic u, input logic el);
        vec[nvec] = '{d: d, l: l, ev: ev, k: k, u: u, el: el};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            pkt_tvalid = 1'b1;
            pkt_tdata  = vec[i].d;
            pkt_tlast  = vec[i].l;
            @(posedge clk);
            #1;
            pkt_tvalid = 1'b0;
            pkt_tdata  = '0;
            pkt_tlast  = 1'b0;
            chk($sformatf("vec%0d", i),
                {vid_tvalid, vid_tdata, vid_tkeep, vid_tuser, vid_tlast},
                {vec[i].ev, vec[i].ev ? vec[i].d : 32'h0, vec[i].k, vec[i].u, vec[i].el});
        end
    endtask

    task automatic pulse(input logic s, input logic p);
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    int fa, fb, f4, fd, fe, f6, fr1, fr2, fend;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0; exp_lines = '0;
        pkt_tvalid = 1'b0; pkt_tdata = '0; pkt_tlast = 1'b0;

        // Frame A: two RAW10 lines of 10 bytes (3 beats each, CRC in beat 3).
        fa = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd10), 0, 0, 4'h0, 0, 0);
        add(32'h11111111, 0, 1, 4'hF, 1, 0);
        add(32'h22222222, 0, 1, 4'hF, 0, 0);
        add(32'h33333333, 1, 1, 4'h3, 0, 1);
        add(hdr(6'h2B, 2'd0, 16'd10), 0, 0, 4'h0, 0, 0);
        add(32'h44444444, 0, 1, 4'hF, 0, 0);
        add(32'h55555555, 0, 1, 4'hF, 0, 0);
        add(32'h66666666, 1, 1, 4'h3, 0, 1);
        add(hdr(6'h01, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        // Frame B: LS/LE, WC=8, WC=0, wrong DT, wrong VC, truncation, WC=6.
        fb = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h02, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd8), 0, 0, 4'h0, 0, 0);
        add(32'hA0A0A0A0, 0, 1, 4'hF, 1, 0);
        add(32'hA1A1A1A1, 0, 1, 4'hF, 0, 1);
        add(32'h0000C3C3, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h03, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd0), 0, 0, 4'h0, 0, 0);
        add(32'h0000BEEF, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2A, 2'd0, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'hDEADBEEF, 0, 0, 4'h0, 0, 0);
        add(32'h00001234, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd1, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'hCAFECAFE, 0, 0, 4'h0, 0, 0);
        add(32'h00005678, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h01, 2'd1, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd16), 0, 0, 4'h0, 0, 0);
        add(32'hB0B0B0B0, 0, 1, 4'hF, 0, 0);
        add(32'hB1B1B1B1, 1, 1, 4'hF, 0, 1);
        add(hdr(6'h2B, 2'd0, 16'd6), 0, 0, 4'h0, 0, 0);
        add(32'hC0C0C0C0, 0, 1, 4'hF, 0, 0);
        add(32'h9999C1C1, 1, 1, 4'h3, 0, 1);
        add(hdr(6'h01, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        // Missing FE, then orphan FE and orphan long packet in WAIT_FS.
        f4 = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'hD0D0D0D0, 0, 1, 4'hF, 1, 1);
        add(32'h0000C3C3, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'hD1D1D1D1, 0, 1, 4'hF, 1, 1);
        add(32'h0000C3C3, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h01, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h01, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'hEEEEEEEE, 1, 0, 4'h0, 0, 0);
        // One-shot: first frame forwarded, second ignored.
        fd = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'h12345678, 0, 1, 4'hF, 1, 1);
        add(32'h0000C3C3, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h01, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        fe = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'h87654321, 0, 0, 4'h0, 0, 0);
        add(32'h0000C3C3, 1, 0, 4'h0, 0, 0);
        add(hdr(6'h01, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        // Stop mid-line: split around a stop pulse.
        f6 = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd10), 0, 0, 4'h0, 0, 0);
        add(32'h77777777, 0, 1, 4'hF, 1, 0);
        fr1 = nvec;
        add(32'h88888888, 0, 1, 4'hF, 0, 0);
        add(32'h00009999, 1, 1, 4'h3, 0, 1);
        add(hdr(6'h01, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        // Reset mid-line, then a fresh frame.
        fr2 = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd10), 0, 0, 4'h0, 0, 0);
        add(32'hABCDABCD, 0, 1, 4'hF, 1, 0);
        fend = nvec;
        add(hdr(6'h00, 2'd0, 16'd0), 1, 0, 4'h0, 0, 0);
        add(hdr(6'h2B, 2'd0, 16'd4), 0, 0, 4'h0, 0, 0);
        add(32'h5A5A5A5A, 0, 1, 4'hF, 1, 1);
        add(32'h0000C3C3, 1, 0, 4'h0, 0, 0);

        #2;
        chk("reset_async", {vid_tvalid, conv_en, busy, frame_cnt, line_cnt, err}, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_state", {vid_tvalid, vid_tdata, conv_en, busy, frame_cnt, line_cnt, err}, '0);

        pulse(1, 1);
        chk("start_stop_same", {conv_en, busy}, 2'b00);
        pulse(1, 0);
        chk("start_arm", {conv_en, busy}, 2'b11);

        run(fa, fb);
        chk("A_stats", {busy, frame_cnt, line_cnt, err}, {1'b1, 16'd1, 16'd2, 3'b000});
        run(fb, f4);
        chk("B_stats", {busy, frame_cnt, line_cnt, err}, {1'b1, 16'd2, 16'd3, 3'b000});

        exp_lines = 16'd2;
        run(f4, f4 + 9);
        chk("missfe_stats", {frame_cnt, line_cnt, err}, {16'd3, 16'd1, 3'b110});
        run(f4 + 9, fd);
        chk("orphan_err", {busy, err}, {1'b1, 3'b111});
        pulse(1, 0);
        chk("start_clears_err", {busy, err}, {1'b1, 3'b000});
        exp_lines = 16'd0;

        pulse(0, 1);
        chk("stop_wait_fs", {conv_en, busy}, 2'b00);
        one_shot = 1'b1;
        pulse(1, 0);
        run(fd, fe);
        chk("oneshot_done", {conv_en, busy, frame_cnt, line_cnt}, {2'b00, 16'd4, 16'd1});
        run(fe, f6);
        chk("oneshot_ignored", {conv_en, busy, frame_cnt}, {2'b00, 16'd4});

        one_shot = 1'b0;
        pulse(1, 0);
        run(f6, fr1);
        pulse(0, 1);
        chk("stop_mid_line_busy", {conv_en, busy}, 2'b11);
        run(fr1, fr2);
        chk("stop_at_fe", {conv_en, busy, frame_cnt, line_cnt, err}, {2'b00, 16'd5, 16'd1, 3'b000});

        pulse(1, 0);
        run(fr2, fend);
        #3 rst_n = 1'b0;
        #1;
        chk("reset_mid_line", {vid_tvalid, vid_tdata, vid_tkeep, vid_tuser, vid_tlast,
                               conv_en, busy, frame_cnt, line_cnt, err}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        pulse(1, 0);
        run(fend, nvec);
        chk("after_reset_stats", {busy, frame_cnt, err}, {1'b1, 16'd0, 3'b000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
